// File: rtl/mem_bus_arbiter.sv
`default_nettype none
// ============================================================================
// Module   : mem_bus_arbiter
// Purpose  : Shares the system memory bus between the CPU and a DMA/loader
//            master. Ownership changes only at safe points (CPU instruction
//            completion, DMA burst end or beat limit). Every handover goes
//            through one dead cycle so that in-flight read data is returned
//            to the master that issued the read.
// Ports    : clk, reset (async, active-high)
//            cpu_*  : CPU request side (req/we/addr/wdata/instr_complete)
//                     and grant / read-return (gnt/rdata/rvalid)
//            dma_*  : DMA request side (req/we/addr/wdata) and grant /
//                     read-return (gnt/rdata/rvalid)
//            mem_*  : muxed bus to memory decode; mem_rdata returns one
//                     cycle after mem_read
//            owner  : 00 IDLE, 01 CPU, 10 DMA, 11 HANDOVER
// Revision : 1.0  initial release
// ============================================================================
module mem_bus_arbiter #(
    parameter int ADDR_WIDTH    = 16,
    parameter int DATA_WIDTH    = 8,
    parameter int DMA_MAX_BEATS = 8
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  cpu_req,
    input  logic                  cpu_we,
    input  logic [ADDR_WIDTH-1:0] cpu_addr,
    input  logic [DATA_WIDTH-1:0] cpu_wdata,
    input  logic                  cpu_instr_complete,
    output logic                  cpu_gnt,
    output logic [DATA_WIDTH-1:0] cpu_rdata,
    output logic                  cpu_rvalid,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [ADDR_WIDTH-1:0] dma_addr,
    input  logic [DATA_WIDTH-1:0] dma_wdata,
    output logic                  dma_gnt,
    output logic [DATA_WIDTH-1:0] dma_rdata,
    output logic                  dma_rvalid,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DATA_WIDTH-1:0] mem_wdata,
    input  logic [DATA_WIDTH-1:0] mem_rdata,
    output logic [1:0]            owner
);

    localparam int c_BEAT_W = $clog2(DMA_MAX_BEATS + 1);
    localparam logic [c_BEAT_W-1:0] c_MAX_BEATS = c_BEAT_W'(DMA_MAX_BEATS);

    // Encoding doubles as the owner status code.
    typedef enum logic [1:0] {
        S_IDLE = 2'b00,
        S_CPU  = 2'b01,
        S_DMA  = 2'b10,
        S_HAND = 2'b11
    } state_t;

    state_t                r_state;
    logic                  r_prev_dma;   // owner before the current HANDOVER
    logic [c_BEAT_W-1:0]   r_beats;
    logic                  r_cpu_tag;    // read issued last cycle by CPU
    logic                  r_dma_tag;    // read issued last cycle by DMA

    logic                  w_cpu_acc;
    logic                  w_dma_acc;
    logic [c_BEAT_W-1:0]   w_beats_next;

    assign w_cpu_acc = (r_state == S_CPU) && cpu_req;
    assign w_dma_acc = (r_state == S_DMA) && dma_req;

    // Count includes the access in flight this cycle, so the access that
    // reaches the limit is the last one before handing back to the CPU.
    assign w_beats_next = (w_dma_acc && (r_beats != c_MAX_BEATS))
                          ? r_beats + c_BEAT_W'(1) : r_beats;

    always_comb begin
        mem_addr  = '0;
        mem_wdata = '0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
        if (w_cpu_acc) begin
            mem_addr  = cpu_addr;
            mem_wdata = cpu_wdata;
            mem_read  = !cpu_we;
            mem_write = cpu_we;
        end else if (w_dma_acc) begin
            mem_addr  = dma_addr;
            mem_wdata = dma_wdata;
            mem_read  = !dma_we;
            mem_write = dma_we;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state    <= S_IDLE;
            r_prev_dma <= 1'b0;
            r_beats    <= '0;
            r_cpu_tag  <= 1'b0;
            r_dma_tag  <= 1'b0;
        end else begin
            // Tags follow the issuing master, independent of the next owner.
            r_cpu_tag <= w_cpu_acc && !cpu_we;
            r_dma_tag <= w_dma_acc && !dma_we;
            // Counter holds zero outside DMA ownership, giving a clean start.
            r_beats   <= '0;
            case (r_state)
                S_IDLE: begin
                    if (cpu_req) begin
                        r_state <= S_CPU;
                    end else if (dma_req) begin
                        r_state <= S_DMA;
                    end
                end
                S_CPU: begin
                    // A waiting DMA gets the bus only at an instruction
                    // boundary or while the CPU has stopped requesting.
                    if (dma_req && (cpu_instr_complete || !cpu_req)) begin
                        r_state    <= S_HAND;
                        r_prev_dma <= 1'b0;
                    end
                end
                S_DMA: begin
                    r_beats <= w_beats_next;
                    if (!dma_req || (cpu_req && (w_beats_next == c_MAX_BEATS))) begin
                        r_state    <= S_HAND;
                        r_prev_dma <= 1'b1;
                    end
                end
                default: begin
                    // Dead cycle: offer the bus to the other master first.
                    if (r_prev_dma ? cpu_req : dma_req) begin
                        r_state <= r_prev_dma ? S_CPU : S_DMA;
                    end else if (r_prev_dma ? dma_req : cpu_req) begin
                        r_state <= r_prev_dma ? S_DMA : S_CPU;
                    end else begin
                        r_state <= S_IDLE;
                    end
                end
            endcase
        end
    end

    assign cpu_gnt    = (r_state == S_CPU);
    assign dma_gnt    = (r_state == S_DMA);
    assign owner      = 2'(r_state);
    assign cpu_rvalid = r_cpu_tag;
    assign dma_rvalid = r_dma_tag;
    assign cpu_rdata  = r_cpu_tag ? mem_rdata : '0;
    assign dma_rdata  = r_dma_tag ? mem_rdata : '0;

endmodule
`default_nettype wire
